// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and count type for the synchronous FIFO
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);

   // One extra bit so a completely full FIFO (count == DEPTH) is representable.
   typedef logic [DEF_ADDR_WIDTH:0] count_t;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port storage, synchronous write, registered read, no reset
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      // Read register only loads on an accepted read, so it holds otherwise.
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO: pointers, count, registered flags and error pulses
module fifo_sync
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  full,
   output logic                  mty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  ovf,
   output logic                  udf
);

   localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LP_PTR_1 = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   LP_CNT_1 = (ADDR_WIDTH+1)'(1);

   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_full;
   logic                  r_mty;
   logic                  r_ovf;
   logic                  r_udf;
   logic                  r_q_vld;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   logic [DATA_WIDTH-1:0] w_ram_q;

   assign w_wr_acc = wr && !r_full;
   assign w_rd_acc = rd && !r_mty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + LP_CNT_1;
      end else if (w_rd_acc && !w_wr_acc) begin
         w_count_nxt = r_count - LP_CNT_1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_mty   <= 1'b1;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
         r_q_vld <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wptr <= r_wptr + LP_PTR_1;
         end
         if (w_rd_acc) begin
            r_rptr  <= r_rptr + LP_PTR_1;
            r_q_vld <= 1'b1;
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == LP_DEPTH);
         r_mty   <= (w_count_nxt == '0);
         r_ovf   <= wr && r_full;
         r_udf   <= rd && r_mty;
      end
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr_acc),
      .i_waddr (r_wptr),
      .i_wdata (data),
      .i_re    (w_rd_acc),
      .i_raddr (r_rptr),
      .o_rdata (w_ram_q)
   );

   // The RAM read register has no reset; mask it until a read lands after reset.
   assign q     = r_q_vld ? w_ram_q : '0;
   assign full  = r_full;
   assign mty   = r_mty;
   assign count = r_count;
   assign ovf   = r_ovf;
   assign udf   = r_udf;

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - directed self-checking bench for fifo_sync
module tb_fifo_sync;
   import fifo_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       wr;
   logic [7:0] data;
   logic       rd;
   logic [7:0] q;
   logic       full;
   logic       mty;
   count_t     count;
   logic       ovf;
   logic       udf;

   int n_checks = 0;
   int n_errors = 0;

   fifo_sync #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr),
      .data  (data),
      .rd    (rd),
      .q     (q),
      .full  (full),
      .mty   (mty),
      .count (count),
      .ovf   (ovf),
      .udf   (udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, let the rising edge take them, sample at the falling edge.
   task automatic step(input logic w, input logic [7:0] d, input logic r);
      wr = w; data = d; rd = r;
      @(posedge clk);
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
   endtask

   initial begin
      wr = 1'b0; rd = 1'b0; data = 8'h00; rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mty", mty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_q", q, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_udf", udf, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single word
      step(1'b1, 8'hA5, 1'b0);
      chk("w1_count", count, 1);
      chk("w1_mty", mty, 0);
      step(1'b0, 8'h00, 1'b1);
      chk("r1_q", q, 8'hA5);
      chk("r1_mty", mty, 1);
      chk("r1_count", count, 0);

      // underflow
      step(1'b0, 8'h00, 1'b1);
      chk("udf_pulse", udf, 1);
      chk("udf_q_hold", q, 8'hA5);
      chk("udf_count", count, 0);
      step(1'b0, 8'h00, 1'b0);
      chk("udf_clear", udf, 0);

      // fill to full, overflow, drain
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      step(1'b1, 8'h77, 1'b0);
      chk("ovf_pulse", ovf, 1);
      chk("ovf_count", count, 16);
      step(1'b0, 8'h00, 1'b0);
      chk("ovf_clear", ovf, 0);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk($sformatf("drain_q%0d", i), q, i);
      end
      chk("drain_mty", mty, 1);
      chk("drain_full", full, 0);

      // full with simultaneous wr/rd
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
      step(1'b1, 8'hEE, 1'b1);
      chk("fboth_q", q, 8'h40);
      chk("fboth_ovf", ovf, 1);
      chk("fboth_count", count, 15);
      chk("fboth_full", full, 0);
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk($sformatf("fboth_drain%0d", i), q, 8'h40 + i);
      end
      chk("fboth_mty", mty, 1);

      // empty with simultaneous wr/rd
      step(1'b1, 8'h99, 1'b1);
      chk("eboth_udf", udf, 1);
      chk("eboth_count", count, 1);
      chk("eboth_q_hold", q, 8'h4F);
      step(1'b0, 8'h00, 1'b1);
      chk("eboth_rd", q, 8'h99);
      chk("eboth_mty", mty, 1);

      // steady-state streaming at count 8, pointers wrap twice
      for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 8'(8 + i), 1'b1);
         chk($sformatf("strm_q%0d", i), q, i);
         chk($sformatf("strm_cnt%0d", i), count, 8);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk($sformatf("strm_tail%0d", i), q, 40 + i);
      end
      chk("strm_mty", mty, 1);

      // asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("pre_rst_count", count, 4);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_mty", mty, 1);
      chk("arst_full", full, 0);
      chk("arst_q", q, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h3C, 1'b0);
      chk("post_rst_count", count, 1);
      step(1'b0, 8'h00, 1'b1);
      chk("post_rst_q", q, 8'h3C);
      chk("post_rst_mty", mty, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of words; power of two, >= 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), pointer width; not overridden by users.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port wr  input  1  write request.
REQ-007 SHALL have port data  input  DATA_WIDTH  write data, sampled with wr.
REQ-008 SHALL have port rd  input  1  read request.
REQ-009 SHALL have port q  output  DATA_WIDTH  read data, registered.
REQ-010 SHALL have port full  output  1  high when count == DEPTH.
REQ-011 SHALL have port mty  output  1  high when count == 0.
REQ-012 SHALL have port count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
REQ-013 SHALL have port ovf  output  1  one-cycle pulse: wr while full.
REQ-014 SHALL have port udf  output  1  one-cycle pulse: rd while mty.

Function
REQ-015 Write accept = wr && !full; on accept, data SHALL be stored at wptr and wptr SHALL increment modulo DEPTH.
REQ-016 Read accept = rd && !mty; on accept, the word at rptr SHALL be registered into q and rptr SHALL increment modulo DEPTH.
REQ-017 Read latency: q SHALL be valid on the first rising edge after the edge that sampled rd high (one cycle); q SHALL hold its value when no read is accepted.
REQ-018 count SHALL be +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-019 full, mty SHALL be registered; they SHALL reflect the updated count in the cycle after the accepting edge, with no combinational path from wr/rd.
REQ-020 Simultaneous wr and rd when full: read SHALL be accepted, write SHALL be rejected, ovf SHALL pulse, count SHALL become DEPTH-1.
REQ-021 Simultaneous wr and rd when empty: write SHALL be accepted, read SHALL be rejected, udf SHALL pulse, q unchanged, count SHALL become 1.
REQ-022 Simultaneous wr and rd, neither full nor empty: both SHALL be accepted; the stored word SHALL be the old rptr entry, not the incoming data.
REQ-023 Rejected writes/reads SHALL NOT alter pointers, count or memory contents.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 with no gap; full/mty SHALL be derived from count, not pointer equality.
REQ-025 ovf and udf SHALL be registered, high for exactly one cycle per offending edge.

Reset
REQ-026 On rst_n low, immediately and independently of clk: wptr=0, rptr=0, count=0, mty=1, full=0, q=0, ovf=0, udf=0.
REQ-027 Memory array contents SHALL NOT be reset; they are unreadable until written.
REQ-028 Reset asserted mid-operation SHALL discard all stored words; the first accepted read after reset SHALL return the first word written after reset.
REQ-029 Release of rst_n SHALL be synchronized externally; the block SHALL accept wr/rd from the first rising edge after release.

Structure
REQ-030 A shared package fifo_pkg SHALL hold default DATA_WIDTH and DEPTH constants and the typedef for count values.
REQ-031 Storage SHALL be a sub-module fifo_ram: simple dual-port, one synchronous write port, one synchronous registered read port, no reset.
REQ-032 fifo_sync SHALL contain pointers, count, flags and error pulses; fifo_ram SHALL contain only storage.

Verification
REQ-033 After reset, write 0xA5 then rd -> q == 0xA5 one cycle after rd edge; mty back to 1, count 0.
REQ-034 Write 16 words 0x00..0x0F (DEPTH=16) -> full=1, count=16; 17th wr -> ovf pulse, count stays 16; 16 reads return 0x00..0x0F in order.
REQ-035 rd on empty FIFO -> udf pulse one cycle, q holds previous value, count 0.
REQ-036 Fill to 8, then 40 cycles wr and rd together with incrementing data -> count stays 8, read sequence exact, pointers wrap twice without loss.
REQ-037 Fill to 5, assert rst_n low between edges -> flags/count/q reset immediately; post-reset write 0x3C, read -> 0x3C.
REQ-038 Full with wr and rd together -> read accepted, ovf pulse, count 15; empty with wr and rd together -> write accepted, udf pulse, count 1.
